// File: rtl/csa_pkg.sv
// Shared helpers for the carry-save reduction tree.
// csa_ops_after(n, l): operand count left after l layers of 3:2 compression,
//                      where each group of 3 becomes 2 and 1-2 leftovers pass.
// csa_layers(n):       number of layers needed to reduce n operands to 2.
package csa_pkg;

    function automatic int csa_ops_after(input int n, input int l);
        int m;
        m = n;
        for (int i = 0; i < l; i++) begin
            m = (m / 3) * 2 + (m % 3);
        end
        return m;
    endfunction

    function automatic int csa_layers(input int n);
        int m;
        int cnt;
        m   = n;
        cnt = 0;
        while (m > 2) begin
            m   = (m / 3) * 2 + (m % 3);
            cnt = cnt + 1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/csa_tree_acc_if.sv
// Operand/result stream bundle for csa_tree_acc.
//   in_valid/in_ready   : operand beat handshake
//   in_data             : NUM_OPS packed signed operands, operand k at [k*IN_W +: IN_W]
//   in_first/in_last    : accumulation group delimiters
//   out_valid/out_ready : result handshake
//   out_data            : signed OUT_W-bit result
// master = producer/consumer side (bench), slave = the reduction tree.
interface csa_tree_acc_if #(
    parameter int NUM_OPS = 8,
    parameter int IN_W    = 16,
    parameter int ACC_EXT = 8
);
    localparam int OUT_W = IN_W + $clog2(NUM_OPS) + ACC_EXT;

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_OPS*IN_W-1:0] in_data;
    logic                    in_first;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;

    modport master (
        output in_valid, in_data, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/csa_row.sv
// Combinational W-bit 3:2 compressor row (a full-adder cell per bit).
//   a, b, c : three addends
//   sum     : bitwise a^b^c
//   carry   : bitwise majority(a,b,c) shifted left by one; bit 0 is 0 and the
//             majority MSB falls off, so sum + carry == a + b + c mod 2^W.
module csa_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    assign carry = maj << 1;

endmodule

// File: rtl/csa_tree_acc.sv
// Pipelined multi-operand carry-save adder tree with optional group accumulate.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : csa_tree_acc_if slave (operand beats in, results out)
// Each beat's NUM_OPS signed operands are sign-extended to OUT_W bits and
// reduced to a sum/carry pair through LAYERS registered 3:2 layers. A final
// registered stage folds in the running accumulator and does the carry-
// propagate add; its register is both the accumulator and out_data.
// The whole pipe advances together whenever the output slot is free.
module csa_tree_acc
    import csa_pkg::*;
#(
    parameter int NUM_OPS = 8,
    parameter int IN_W    = 16,
    parameter int ACC_EXT = 8,
    parameter int ACC_EN  = 1
) (
    input logic           clk,
    input logic           rst_n,
    csa_tree_acc_if.slave bus
);
    localparam int OUT_W  = IN_W + $clog2(NUM_OPS) + ACC_EXT;
    localparam int LAYERS = csa_layers(NUM_OPS);

    logic             advance;
    logic             accept;
    logic [OUT_W-1:0] in_ext [NUM_OPS];
    logic [OUT_W-1:0] nxt    [1:LAYERS][NUM_OPS];
    logic [OUT_W-1:0] ops_q  [1:LAYERS][NUM_OPS];
    logic [LAYERS:1]  vld_q;
    logic [LAYERS:1]  first_q;
    logic [LAYERS:1]  last_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_base;
    logic [OUT_W-1:0] fin_sum;
    logic [OUT_W-1:0] fin_carry;
    logic [OUT_W-1:0] result;

    // Single global stall: every stage moves only when the result slot is free.
    assign advance       = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && advance;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
        assign in_ext[k] = {{(OUT_W - IN_W){bus.in_data[k*IN_W + IN_W - 1]}},
                            bus.in_data[k*IN_W +: IN_W]};
    end

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        localparam int N_IN  = csa_ops_after(NUM_OPS, l);
        localparam int GRP   = N_IN / 3;
        localparam int REM   = N_IN % 3;
        localparam int N_OUT = 2 * GRP + REM;

        logic [OUT_W-1:0] src [NUM_OPS];

        if (l == 0) begin : g_src_in
            assign src = in_ext;
        end else begin : g_src_reg
            assign src = ops_q[l];
        end

        for (genvar g = 0; g < GRP; g++) begin : g_row
            csa_row #(.W(OUT_W)) u_row (
                .a    (src[3*g]),
                .b    (src[3*g+1]),
                .c    (src[3*g+2]),
                .sum  (nxt[l+1][2*g]),
                .carry(nxt[l+1][2*g+1])
            );
        end

        // Operands that do not fill a group of three ride through untouched.
        for (genvar r = 0; r < REM; r++) begin : g_pass
            assign nxt[l+1][2*GRP+r] = src[3*GRP+r];
        end

        for (genvar z = N_OUT; z < NUM_OPS; z++) begin : g_zero
            assign nxt[l+1][z] = '0;
        end
    end

    // NOTE: operand and first/last registers have no reset; they are only
    // consumed when the matching valid bit (which is reset) says so.
    always_ff @(posedge clk) begin
        if (advance) begin
            first_q[1] <= bus.in_first;
            last_q[1]  <= bus.in_last;
            for (int l = 2; l <= LAYERS; l++) begin
                first_q[l] <= first_q[l-1];
                last_q[l]  <= last_q[l-1];
            end
            for (int l = 1; l <= LAYERS; l++) begin
                for (int k = 0; k < NUM_OPS; k++) begin
                    ops_q[l][k] <= nxt[l][k];
                end
            end
        end
    end

    // A group restarts from zero on first; otherwise the previous result is
    // folded in, which also covers beats arriving between groups.
    assign acc_base = (ACC_EN == 0 || first_q[LAYERS]) ? '0 : acc_q;

    csa_row #(.W(OUT_W)) u_final (
        .a    (ops_q[LAYERS][0]),
        .b    (ops_q[LAYERS][1]),
        .c    (acc_base),
        .sum  (fin_sum),
        .carry(fin_carry)
    );

    assign result = fin_sum + fin_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else if (advance) begin
            vld_q[1] <= accept;
            for (int l = 2; l <= LAYERS; l++) begin
                vld_q[l] <= vld_q[l-1];
            end
            out_valid_q <= vld_q[LAYERS] && (ACC_EN == 0 || last_q[LAYERS]);
            if (vld_q[LAYERS]) begin
                acc_q <= result;
            end
        end
    end

endmodule

// File: tb/tb_csa_tree_acc.sv
// Scoreboard bench for csa_tree_acc: one instance with ACC_EN=0 and one with
// ACC_EN=1 share the stimulus signals; 'sel' routes beats to one of them and
// the monitor watches the selected instance.
module tb_csa_tree_acc;
    localparam int NUM_OPS = 8;
    localparam int IN_W    = 16;
    localparam int ACC_EXT = 8;
    localparam int OUT_W   = 27;
    localparam int LAT     = 5;
    localparam int DW      = NUM_OPS * IN_W;

    typedef struct {
        logic signed [OUT_W-1:0] data;
        int                      acc_cyc;
        bit                      chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel;
    logic          tb_valid;
    logic          tb_first;
    logic          tb_last;
    logic          tb_ready;
    logic [DW-1:0] tb_data;

    logic             m_in_ready;
    logic             m_out_valid;
    logic [OUT_W-1:0] m_out_data;

    csa_tree_acc_if #(.NUM_OPS(NUM_OPS), .IN_W(IN_W), .ACC_EXT(ACC_EXT)) bus0 ();
    csa_tree_acc_if #(.NUM_OPS(NUM_OPS), .IN_W(IN_W), .ACC_EXT(ACC_EXT)) bus1 ();

    csa_tree_acc #(.NUM_OPS(NUM_OPS), .IN_W(IN_W), .ACC_EXT(ACC_EXT), .ACC_EN(0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    csa_tree_acc #(.NUM_OPS(NUM_OPS), .IN_W(IN_W), .ACC_EXT(ACC_EXT), .ACC_EN(1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    assign bus0.in_valid  = tb_valid && !sel;
    assign bus1.in_valid  = tb_valid && sel;
    assign bus0.in_data   = tb_data;
    assign bus1.in_data   = tb_data;
    assign bus0.in_first  = tb_first;
    assign bus1.in_first  = tb_first;
    assign bus0.in_last   = tb_last;
    assign bus1.in_last   = tb_last;
    assign bus0.out_ready = tb_ready;
    assign bus1.out_ready = tb_ready;

    assign m_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
    assign m_out_valid = sel ? bus1.out_valid : bus0.out_valid;
    assign m_out_data  = sel ? bus1.out_data  : bus0.out_data;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     ready_mode = 0;
    exp_t   sb[$];
    longint acc_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer sum of the signed operands, wrapped to OUT_W.
    function automatic longint beat_sum(input logic [DW-1:0] d);
        longint s;
        logic signed [IN_W-1:0] op;
        s = 0;
        for (int k = 0; k < NUM_OPS; k++) begin
            op = d[k*IN_W +: IN_W];
            s  = s + longint'(op);
        end
        return s;
    endfunction

    function automatic logic signed [OUT_W-1:0] wrapv(input longint v);
        return v[OUT_W-1:0];
    endfunction

    function automatic logic [DW-1:0] pack_all(input int v);
        logic [DW-1:0] d;
        for (int k = 0; k < NUM_OPS; k++) d[k*IN_W +: IN_W] = IN_W'(v);
        return d;
    endfunction

    function automatic logic [DW-1:0] pack_rand();
        logic [DW-1:0] d;
        for (int k = 0; k < NUM_OPS; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
        return d;
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input bit first,
                                input bit last, input bit chk_lat);
        exp_t   e;
        longint s;
        s = beat_sum(d);
        e.acc_cyc = cyc;
        e.chk_lat = chk_lat;
        if (!sel) begin
            e.data = wrapv(s);
            sb.push_back(e);
        end else begin
            acc_m = first ? s : acc_m + s;
            if (last) begin
                e.data = wrapv(acc_m);
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit first,
                             input bit last, input bit chk_lat);
        bit done;
        done     = 1'b0;
        tb_valid = 1'b1;
        tb_data  = d;
        tb_first = first;
        tb_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (m_in_ready) begin
                model_accept(d, first, last, chk_lat);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        tb_valid = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = never ready.
    initial begin
        int pat;
        pat = 0;
        tb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tb_ready = 1'b1;
                1: begin
                    tb_ready = (pat == 0);
                    pat = (pat + 1) % 3;
                end
                default: tb_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expectation per newly presented result and checks
    // that a stalled result stays put until it is taken.
    initial begin
        bit               held;
        logic [OUT_W-1:0] held_data;
        exp_t             e;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", m_out_valid, 1);
                    check("hold_data", $signed(m_out_data), $signed(held_data));
                end
                if (m_out_valid && !held) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", $signed(m_out_data), -1);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", $signed(m_out_data), e.data);
                        if (e.chk_lat) check("latency", cyc - e.acc_cyc, LAT);
                    end
                end
                held      = m_out_valid && !tb_ready;
                held_data = m_out_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int seen;
        sel      = 1'b0;
        tb_valid = 1'b0;
        tb_first = 1'b0;
        tb_last  = 1'b0;
        tb_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready0",  bus0.in_ready,  1);
        check("rst_out_valid0", bus0.out_valid, 0);
        check("rst_out_data0",  bus0.out_data,  0);
        check("rst_in_ready1",  bus1.in_ready,  1);
        check("rst_out_valid1", bus1.out_valid, 0);
        check("rst_out_data1",  bus1.out_data,  0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ACC_EN=0: operands 1..8, latency measured.
        for (int k = 0; k < NUM_OPS; k++) d[k*IN_W +: IN_W] = IN_W'(k + 1);
        send_beat(d, 1'b0, 1'b0, 1'b1);
        wait_drain();
        send_beat(pack_all(-32768), 1'b0, 1'b0, 1'b1);
        send_beat(pack_all(32767), 1'b0, 1'b0, 1'b0);
        wait_drain();

        // Back-to-back random stream with out_ready pattern 1,0,0.
        ready_mode = 1;
        for (int i = 0; i < 20; i++) send_beat(pack_rand(), 1'b0, 1'b0, 1'b0);
        wait_drain();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // ACC_EN=1 groups.
        sel = 1'b1;
        @(posedge clk);
        #1;
        send_beat(pack_all(1), 1'b1, 1'b0, 1'b0);
        send_beat(pack_all(1), 1'b0, 1'b0, 1'b0);
        send_beat(pack_all(1), 1'b0, 1'b1, 1'b1);
        d = '0;
        d[IN_W-1:0] = IN_W'(5);
        send_beat(d, 1'b1, 1'b1, 1'b1);
        // Beat outside any group keeps accumulating on the previous result.
        send_beat(pack_rand(), 1'b0, 1'b1, 1'b0);
        wait_drain();

        // Random groups with bubbles and stalls.
        ready_mode = 1;
        for (int g = 0; g < 4; g++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                send_beat(pack_rand(), b == 0, b == len - 1, 1'b0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
        ready_mode = 0;

        // 2^ACC_EXT+1 most-negative beats: accumulation wraps.
        for (int i = 0; i <= (1 << ACC_EXT); i++)
            send_beat(pack_all(-32768), i == 0, i == (1 << ACC_EXT), 1'b0);
        wait_drain();

        // Reset with a stalled result and three beats of an open group in flight.
        ready_mode = 2;
        @(posedge clk);
        #2;
        d = '0;
        d[IN_W-1:0] = IN_W'(7);
        send_beat(d, 1'b1, 1'b1, 1'b0);
        send_beat(pack_rand(), 1'b1, 1'b0, 1'b0);
        send_beat(pack_rand(), 1'b0, 1'b0, 1'b0);
        send_beat(pack_rand(), 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_out_valid", bus1.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", bus1.out_valid, 0);
        check("rst_mid_out_data",  bus1.out_data,  0);
        sb.delete();
        acc_m = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ready_mode = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus1.out_valid) seen++;
        end
        check("no_stale_out", seen, 0);
        @(posedge clk);
        #1;
        send_beat(pack_rand(), 1'b1, 1'b0, 1'b0);
        send_beat(pack_rand(), 1'b0, 1'b0, 1'b0);
        send_beat(pack_rand(), 1'b0, 1'b1, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
